// File: rtl/ow_slave_resp_if.sv
// 1-Wire responder bus bundle: raw DQ level in, open-drain pull enable out, ROM ID and status.
// slave modport is the responder; master modport is the bus/host side.
interface ow_slave_resp_if;
  logic        DQ_IN;
  logic        DQ_PULLDN;
  logic [63:0] ROMID;
  logic        RESET_SEEN;
  logic        MATCHED;
  logic        CMD_VALID;
  logic [7:0]  CMD;

  modport slave (
    input  DQ_IN, ROMID,
    output DQ_PULLDN, RESET_SEEN, MATCHED, CMD_VALID, CMD
  );

  modport master (
    output DQ_IN, ROMID,
    input  DQ_PULLDN, RESET_SEEN, MATCHED, CMD_VALID, CMD
  );
endinterface

// File: rtl/ow_slave_resp.sv
// 1-Wire slave: presence pulse, Read/Match/Skip ROM vs ROMID, function bytes on CMD/CMD_VALID.
// DQ edges act 3 CLK after the pin; bus-timed, no backpressure. OW_SEARCH_EN adds Search ROM (0xF0).
module ow_slave_resp #(
  parameter int TICKS_PER_US = 4,
  parameter int RST_MIN_US   = 480,
  parameter int PD_WAIT_US   = 30,
  parameter int PD_LEN_US    = 120,
  parameter int SAMPLE_US    = 30
) (
  input  logic           CLK,
  input  logic           MR,
  ow_slave_resp_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PD_DELAY = 3'd1;
  localparam logic [2:0] S_PD_DRIVE = 3'd2;
  localparam logic [2:0] S_ROM_CMD  = 3'd3;
  localparam logic [2:0] S_TX_ROM   = 3'd4;
  localparam logic [2:0] S_RX_MATCH = 3'd5;
  localparam logic [2:0] S_FUNC     = 3'd6;
`ifdef OW_SEARCH_EN
  localparam logic [2:0] S_SEARCH   = 3'd7;
`endif

  localparam logic [15:0] RST_T      = 16'(RST_MIN_US * TICKS_PER_US);
  localparam logic [15:0] PD_WAIT_END = 16'(PD_WAIT_US * TICKS_PER_US - 1);
  localparam logic [15:0] PD_LEN_END  = 16'(PD_LEN_US * TICKS_PER_US - 1);
  localparam logic [15:0] SAMPLE_END  = 16'(SAMPLE_US * TICKS_PER_US - 1);

  logic        dq_m, dq_s, dq_d;
  logic [15:0] low_cnt, tmr;
  logic [2:0]  state, bit_cnt;
  logic [5:0]  rom_cnt;
  logic [7:0]  sr, cmd;
  logic        slot_busy, miss, pull, reset_seen, matched, cmd_vld;
`ifdef OW_SEARCH_EN
  logic [1:0]  phase;
`endif

  logic        fall, rise, reset_det, rom_bit, tx_slot, tx_bit, slot_start, miss_n;
  logic [7:0]  byte_in;

  always_comb begin
    fall       = dq_d & ~dq_s;
    rise       = ~dq_d & dq_s;
    reset_det  = rise && (low_cnt >= RST_T);
    rom_bit    = bus.ROMID[rom_cnt];
    tx_slot    = (state == S_TX_ROM);
    tx_bit     = rom_bit;
`ifdef OW_SEARCH_EN
    // Search triplet: true bit, complement bit, then the master's choice.
    if (state == S_SEARCH && phase != 2'd2) begin
      tx_slot = 1'b1;
      tx_bit  = (phase == 2'd0) ? rom_bit : ~rom_bit;
    end
`endif
    slot_start = (state >= S_ROM_CMD) && fall && !slot_busy;
    byte_in    = {dq_s, sr[7:1]};
    miss_n     = miss | (dq_s != rom_bit);
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      dq_m       <= 1'b1;
      dq_s       <= 1'b1;
      dq_d       <= 1'b1;
      low_cnt    <= '0;
      tmr        <= '0;
      state      <= S_IDLE;
      bit_cnt    <= '0;
      rom_cnt    <= '0;
      sr         <= '0;
      cmd        <= '0;
      slot_busy  <= 1'b0;
      miss       <= 1'b0;
      pull       <= 1'b0;
      reset_seen <= 1'b0;
      matched    <= 1'b0;
      cmd_vld    <= 1'b0;
`ifdef OW_SEARCH_EN
      phase      <= '0;
`endif
    end else begin
      dq_m       <= bus.DQ_IN;
      dq_s       <= dq_m;
      dq_d       <= dq_s;
      low_cnt    <= dq_s ? 16'd0 : ((low_cnt < RST_T) ? low_cnt + 16'd1 : low_cnt);
      reset_seen <= 1'b0;
      cmd_vld    <= 1'b0;

      if (reset_det) begin
        reset_seen <= 1'b1;
        matched    <= 1'b0;
        pull       <= 1'b0;
        slot_busy  <= 1'b0;
        tmr        <= '0;
        bit_cnt    <= '0;
        rom_cnt    <= '0;
        miss       <= 1'b0;
        state      <= S_PD_DELAY;
`ifdef OW_SEARCH_EN
        phase      <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: ;
          S_PD_DELAY: begin
            if (tmr == PD_WAIT_END) begin
              tmr   <= '0;
              pull  <= 1'b1;
              state <= S_PD_DRIVE;
            end else begin
              tmr <= tmr + 16'd1;
            end
          end
          S_PD_DRIVE: begin
            if (tmr == PD_LEN_END) begin
              tmr   <= '0;
              pull  <= 1'b0;
              state <= S_ROM_CMD;
            end else begin
              tmr <= tmr + 16'd1;
            end
          end
          default: begin
            if (slot_start) begin
              slot_busy <= 1'b1;
              tmr       <= '0;
              if (tx_slot && !tx_bit) pull <= 1'b1;
            end else if (slot_busy) begin
              if (tmr != SAMPLE_END) begin
                tmr <= tmr + 16'd1;
              end else begin
                // End of hold/sample window: dq_s is the received bit for write slots.
                slot_busy <= 1'b0;
                pull      <= 1'b0;
                tmr       <= '0;
                case (state)
                  S_ROM_CMD: begin
                    sr      <= byte_in;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                      rom_cnt <= '0;
                      miss    <= 1'b0;
                      case (byte_in)
                        8'h33:   state <= S_TX_ROM;
                        8'h55:   state <= S_RX_MATCH;
                        8'hCC: begin
                          matched <= 1'b1;
                          state   <= S_FUNC;
                        end
`ifdef OW_SEARCH_EN
                        8'hF0: begin
                          phase <= '0;
                          state <= S_SEARCH;
                        end
`endif
                        default: state <= S_IDLE;
                      endcase
                    end
                  end
                  S_TX_ROM: begin
                    rom_cnt <= rom_cnt + 6'd1;
                    if (rom_cnt == 6'd63) begin
                      matched <= 1'b1;
                      state   <= S_FUNC;
                    end
                  end
                  S_RX_MATCH: begin
                    miss    <= miss_n;
                    rom_cnt <= rom_cnt + 6'd1;
                    if (rom_cnt == 6'd63) begin
                      matched <= ~miss_n;
                      state   <= miss_n ? S_IDLE : S_FUNC;
                    end
                  end
                  S_FUNC: begin
                    sr      <= byte_in;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                      cmd     <= byte_in;
                      cmd_vld <= 1'b1;
                    end
                  end
`ifdef OW_SEARCH_EN
                  S_SEARCH: begin
                    if (phase != 2'd2) begin
                      phase <= phase + 2'd1;
                    end else begin
                      phase <= '0;
                      if (dq_s != rom_bit) begin
                        state <= S_IDLE;
                      end else begin
                        rom_cnt <= rom_cnt + 6'd1;
                        if (rom_cnt == 6'd63) begin
                          matched <= 1'b1;
                          state   <= S_FUNC;
                        end
                      end
                    end
                  end
`endif
                  default: ;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.DQ_PULLDN  = pull;
  assign bus.RESET_SEEN = reset_seen;
  assign bus.MATCHED    = matched;
  assign bus.CMD_VALID  = cmd_vld;
  assign bus.CMD        = cmd;

endmodule
